shift_issue: RTL

//  Issue/retire wrapper that sits directly upstream and downstream of barrel_shifter in the execute stage.

---
 rtl/shift_issue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/shift_issue.sv
// rtl/shift_issue.sv - issue/retire wrapper around the registered barrel shifter
// Credit-gated three-stage control pipe feeding an in-order tagged result FIFO.
module shift_issue #(
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_operand,
  input  logic [5:0]       in_amount,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      sh_value_o,
  output logic [1:0]       sh_kind_o,
  output logic [5:0]       sh_amount_o,
  input  logic [63:0]      sh_result_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 2;

  logic             s0_v, s1_v, s2_v;
  logic [63:0]      s0_operand;
  logic [1:0]       s0_kind, s1_kind;
  logic [5:0]       s0_amt, s1_amt;
  logic [TAG_W-1:0] s0_tag, s1_tag, s2_tag;
  logic             s0_w, s1_w, s2_w;

  logic [63:0]      data_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic             is_mov, is_w, accept, push, pop;
  logic [1:0]       dec_kind;
  logic [5:0]       dec_amt;
  logic [63:0]      prepped, post;
  logic [SUM_W-1:0] credits_used;

  always_comb begin
    is_mov   = (in_op[1:0] == 2'b11);
    is_w     = in_op[2] & ~is_mov;
    dec_kind = is_mov ? 2'b11 : in_op[1:0];
    dec_amt  = is_w ? {1'b0, in_amount[4:0]} : in_amount;
    case (in_op)
      3'b101:  prepped = {32'b0, in_operand[31:0]};
      3'b110:  prepped = {{32{in_operand[31]}}, in_operand[31:0]};
      default: prepped = in_operand;
    endcase
  end

  // Every op in flight already owns a FIFO slot, so the shifter can never be back-pressured.
  always_comb begin
    credits_used = SUM_W'(count) + SUM_W'(s0_v) + SUM_W'(s1_v) + SUM_W'(s2_v);
    in_ready     = (credits_used < SUM_W'(FIFO_DEPTH));
  end

  assign accept = in_valid && in_ready && !flush;
  assign push   = s2_v;
  assign pop    = out_ready && (count != '0);
  assign post   = s2_w ? {{32{sh_result_i[31]}}, sh_result_i[31:0]} : sh_result_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0_v       <= 1'b0;
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s0_operand <= '0;
      s0_kind    <= '0;
      s1_kind    <= '0;
      s0_amt     <= '0;
      s1_amt     <= '0;
      s0_tag     <= '0;
      s1_tag     <= '0;
      s2_tag     <= '0;
      s0_w       <= 1'b0;
      s1_w       <= 1'b0;
      s2_w       <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else begin
      // Payload registers only load behind a valid so sh_* hold during bubbles.
      if (accept) begin
        s0_operand <= prepped;
        s0_kind    <= dec_kind;
        s0_amt     <= dec_amt;
        s0_tag     <= in_tag;
        s0_w       <= is_w;
      end
      if (s0_v) begin
        s1_kind <= s0_kind;
        s1_amt  <= s0_amt;
        s1_tag  <= s0_tag;
        s1_w    <= s0_w;
      end
      if (s1_v) begin
        s2_tag <= s1_tag;
        s2_w   <= s1_w;
      end

      if (flush) begin
        s0_v  <= 1'b0;
        s1_v  <= 1'b0;
        s2_v  <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        s0_v <= accept;
        s1_v <= s0_v;
        s2_v <= s1_v;
        if (push) begin
          data_mem[tail] <= post;
          tag_mem[tail]  <= s2_tag;
          tail           <= tail + PTR_W'(1);
        end
        if (pop) head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && push && !pop)
      assert (count < CNT_W'(FIFO_DEPTH));
  end

  assign sh_value_o  = s0_operand;
  assign sh_kind_o   = s1_kind;
  assign sh_amount_o = s1_amt;
  assign out_valid   = (count != '0);
  assign out_data    = data_mem[head];
  assign out_tag     = tag_mem[head];

endmodule
